update_scheduler: RTL and testbench

//  Turns the periodic tick from the strobe generator into per-consumer update requests.

---
 rtl/update_scheduler.sv | 134 +++++++++++++
 tb/tb_update_scheduler.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/update_scheduler.sv
// Per-channel tick dividers feeding a pending register that is served one
// channel at a time, lowest index first, over a req/ack handshake.
module update_scheduler #(
    parameter int N_CH        = 4,
    parameter int DIV_W       = 8,
    parameter int TIMEOUT_CYC = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  tick_i,
    input  logic                  enable_i,
    input  logic [N_CH*DIV_W-1:0] div_i,
    input  logic [N_CH-1:0]       ack_i,
    input  logic                  clr_i,
    output logic [N_CH-1:0]       req_o,
    output logic                  busy_o,
    output logic [N_CH-1:0]       overrun_o,
    output logic [N_CH-1:0]       timeout_o
);

    localparam int TMR_W = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

    typedef enum logic {
        IDLE,
        WAIT_ACK
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    cnt_q [N_CH];
    logic [N_CH-1:0]     due;
    logic [N_CH-1:0]     done;
    logic [N_CH-1:0]     timeoutSet;
    logic [N_CH-1:0]     pend_q, pend_d;
    logic [N_CH-1:0]     req_q, req_d;
    logic [N_CH-1:0]     overrun_q, overrun_d;
    logic [N_CH-1:0]     timeout_q, timeout_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [SEL_W-1:0]    firstIdx;
    logic [TMR_W-1:0]    timer_q, timer_d;

    // ">=" rather than "==" so a divider lowered below the count fires next tick
    always_comb begin
        due = '0;
        for (int k = 0; k < N_CH; k++) begin
            due[k] = tick_i & enable_i & (cnt_q[k] >= div_i[k*DIV_W +: DIV_W]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '{default: '0};
        end else if (tick_i && enable_i) begin
            for (int k = 0; k < N_CH; k++) begin
                cnt_q[k] <= due[k] ? '0 : cnt_q[k] + 1'b1;
            end
        end
    end

    always_comb begin
        firstIdx = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (pend_q[k]) firstIdx = SEL_W'(k);
        end
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        req_d      = req_q;
        timer_d    = timer_q;
        done       = '0;
        timeoutSet = '0;
        case (state_q)
            IDLE: begin
                if (|pend_q) begin
                    sel_d   = firstIdx;
                    req_d   = N_CH'(1) << firstIdx;
                    timer_d = '0;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (ack_i[sel_q]) begin
                    req_d       = '0;
                    done[sel_q] = 1'b1;
                    state_d     = IDLE;
                end else if (TIMEOUT_CYC != 0 && timer_q == TMR_LAST) begin
                    req_d             = '0;
                    done[sel_q]       = 1'b1;
                    timeoutSet[sel_q] = 1'b1;
                    state_d           = IDLE;
                end else if (timer_q != '1) begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A due on an already pending channel is an overrun unless that channel completes this cycle
    always_comb begin
        pend_d    = (pend_q & ~done) | due;
        overrun_d = clr_i ? '0 : (overrun_q | (due & pend_q & ~done));
        timeout_d = clr_i ? '0 : (timeout_q | timeoutSet);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            req_q     <= '0;
            timer_q   <= '0;
            pend_q    <= '0;
            overrun_q <= '0;
            timeout_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            req_q     <= req_d;
            timer_q   <= timer_d;
            pend_q    <= pend_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
        end
    end

    assign req_o     = req_q;
    assign busy_o    = (state_q == WAIT_ACK);
    assign overrun_o = overrun_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_update_scheduler.sv
// Directed bench for update_scheduler: a request scoreboard on a no-timeout
// instance plus direct checks of the abandon path on a TIMEOUT_CYC=5 instance.
module tb_update_scheduler;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        tick, tick5, enable, clr;
    logic [31:0] div0Vec, div5Vec;
    logic [3:0]  ackMan, ack0;
    logic [3:0]  req0, ovr0, tmo0, req5, ovr5, tmo5;
    logic        busy0, busy5;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int rises  = 0;
    int ackMode = 0;
    logic [3:0] reqSeen = '0;
    logic [3:0] prevReq = '0;

    typedef struct {
        logic [3:0] req;
        int         cycle;
    } exp_t;
    exp_t expQ[$];
    exp_t e;

    update_scheduler #(.N_CH(4), .DIV_W(8), .TIMEOUT_CYC(0)) dut0 (
        .clk_i(clk_i), .rst_ni(rst_ni), .tick_i(tick), .enable_i(enable),
        .div_i(div0Vec), .ack_i(ack0), .clr_i(clr), .req_o(req0),
        .busy_o(busy0), .overrun_o(ovr0), .timeout_o(tmo0)
    );

    update_scheduler #(.N_CH(4), .DIV_W(8), .TIMEOUT_CYC(5)) dut5 (
        .clk_i(clk_i), .rst_ni(rst_ni), .tick_i(tick5), .enable_i(enable),
        .div_i(div5Vec), .ack_i(4'b0000), .clr_i(clr), .req_o(req5),
        .busy_o(busy5), .overrun_o(ovr5), .timeout_o(tmo5)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        cyc     <= cyc + 1;
        reqSeen <= req0;
    end

    // Mode 1 acks in the rise cycle, mode 2 one cycle later, mode 0 uses ackMan.
    assign ack0 = (ackMode == 1) ? req0 : (ackMode == 2) ? (req0 & reqSeen) : ackMan;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input logic tickV, input logic [3:0] ackV, input logic clrV);
        tick   = tickV;
        ackMan = ackV;
        clr    = clrV;
        waitCycles(1);
        tick   = 1'b0;
        ackMan = '0;
        clr    = 1'b0;
    endtask

    task automatic doReset();
        rst_ni = 1'b0;
        waitCycles(2);
        rst_ni = 1'b1;
        waitCycles(1);
    endtask

    // Each rising request is matched against the oldest expectation.
    always @(negedge clk_i) begin
        if (req0 != 4'b0000 && prevReq == 4'b0000) begin
            rises++;
            if (expQ.size() == 0) begin
                checkOutput("unexpected_req", {28'h0, req0}, 32'h0);
            end else begin
                e = expQ.pop_front();
                checkOutput("req_value", {28'h0, req0}, {28'h0, e.req});
                checkOutput("req_cycle", cyc, e.cycle);
            end
        end
        prevReq = req0;
    end

    initial begin
        int T;
        int r;
        int modelCnt;
        tick = 0; tick5 = 0; enable = 1; clr = 0; ackMan = '0;
        div0Vec = '0;
        div5Vec = 32'hFFFF_0000;
        rst_ni = 1'b1;
        #2 rst_ni = 1'b0;
        #1;
        checkOutput("rst_req", {28'h0, req0}, 32'h0);
        checkOutput("rst_busy", {31'h0, busy0}, 32'h0);
        checkOutput("rst_overrun", {28'h0, ovr0}, 32'h0);
        checkOutput("rst_timeout", {28'h0, tmo0}, 32'h0);
        checkOutput("rst_req5", {28'h0, req5}, 32'h0);
        waitCycles(2);
        rst_ni = 1'b1;
        waitCycles(1);

        $display("[TB] all channels due on one tick, delayed ack");
        ackMode = 2;
        T = cyc;
        expQ.push_back('{4'b0001, T + 2});
        expQ.push_back('{4'b0010, T + 5});
        expQ.push_back('{4'b0100, T + 8});
        expQ.push_back('{4'b1000, T + 11});
        applyStimulus(1'b1, 4'b0000, 1'b0);
        waitCycles(14);
        checkOutput("t1_drained", expQ.size(), 32'd0);
        checkOutput("t1_overrun", {28'h0, ovr0}, 32'h0);

        $display("[TB] enable low blocks new requests");
        enable = 1'b0;
        r = rises;
        applyStimulus(1'b1, 4'b0000, 1'b0);
        waitCycles(6);
        checkOutput("en_no_req", rises - r, 32'd0);
        enable = 1'b1;

        $display("[TB] divide-by-3 on channel 0, immediate ack");
        doReset();
        ackMode  = 1;
        div0Vec  = 32'hFFFF_FF02;
        r        = rises;
        modelCnt = 0;
        for (int i = 0; i < 9; i++) begin
            T = cyc;
            if (modelCnt >= 2) begin
                expQ.push_back('{4'b0001, T + 2});
                modelCnt = 0;
            end else begin
                modelCnt++;
            end
            applyStimulus(1'b1, 4'b0000, 1'b0);
            waitCycles(19);
        end
        checkOutput("t2_req_count", rises - r, 32'd3);
        checkOutput("t2_overrun", {28'h0, ovr0}, 32'h0);

        $display("[TB] consumer never acks, overrun then clear");
        doReset();
        ackMode = 0;
        div0Vec = 32'hFFFF_00FF;
        T = cyc;
        expQ.push_back('{4'b0010, T + 2});
        applyStimulus(1'b1, 4'b0000, 1'b0);
        waitCycles(9);
        checkOutput("t3_req_held", {28'h0, req0}, 32'h2);
        checkOutput("t3_no_overrun_yet", {28'h0, ovr0}, 32'h0);
        applyStimulus(1'b1, 4'b0000, 1'b0);
        checkOutput("t3_overrun", {28'h0, ovr0}, 32'h2);
        checkOutput("t3_req_still", {28'h0, req0}, 32'h2);
        checkOutput("t3_busy", {31'h0, busy0}, 32'h1);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("t3_overrun_clr", {28'h0, ovr0}, 32'h0);
        applyStimulus(1'b0, 4'b0010, 1'b0);
        checkOutput("t3_req_drop", {28'h0, req0}, 32'h0);
        waitCycles(4);
        checkOutput("t3_no_requeue", {28'h0, req0}, 32'h0);

        $display("[TB] ack coincident with a due tick");
        doReset();
        div0Vec = 32'hFFFF_FF00;
        T = cyc;
        expQ.push_back('{4'b0001, T + 2});
        applyStimulus(1'b1, 4'b0000, 1'b0);
        waitCycles(1);
        checkOutput("t5_req_up", {28'h0, req0}, 32'h1);
        T = cyc;
        expQ.push_back('{4'b0001, T + 2});
        applyStimulus(1'b1, 4'b0001, 1'b0);
        checkOutput("t5_idle_gap", {28'h0, req0}, 32'h0);
        checkOutput("t5_overrun", {28'h0, ovr0}, 32'h0);
        waitCycles(1);
        checkOutput("t5_req_again", {28'h0, req0}, 32'h1);
        applyStimulus(1'b0, 4'b0001, 1'b0);
        checkOutput("t5_overrun_end", {28'h0, ovr0}, 32'h0);
        waitCycles(3);
        checkOutput("t5_drained", expQ.size(), 32'd0);

        $display("[TB] timeout after five cycles");
        T = cyc;
        tick5 = 1'b1;
        waitCycles(1);
        tick5 = 1'b0;
        waitCycles(1);
        checkOutput("t4_req_ch0", {28'h0, req5}, 32'h1);
        checkOutput("t4_busy", {31'h0, busy5}, 32'h1);
        waitCycles(4);
        checkOutput("t4_req_5th", {28'h0, req5}, 32'h1);
        checkOutput("t4_tmo_none", {28'h0, tmo5}, 32'h0);
        waitCycles(1);
        checkOutput("t4_req_drop", {28'h0, req5}, 32'h0);
        checkOutput("t4_tmo_ch0", {28'h0, tmo5}, 32'h1);
        waitCycles(1);
        checkOutput("t4_req_ch1", {28'h0, req5}, 32'h2);
        waitCycles(5);
        checkOutput("t4_req_drop1", {28'h0, req5}, 32'h0);
        checkOutput("t4_tmo_both", {28'h0, tmo5}, 32'h3);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("t4_tmo_clr", {28'h0, tmo5}, 32'h0);

        $display("[TB] reset during WAIT_ACK");
        doReset();
        ackMode = 0;
        div0Vec = 32'hFFFF_FF00;
        applyStimulus(1'b1, 4'b0000, 1'b0);
        waitCycles(1);
        checkOutput("t6_req_before", {28'h0, req0}, 32'h1);
        rst_ni = 1'b0;
        #1;
        checkOutput("t6_req_async", {28'h0, req0}, 32'h0);
        checkOutput("t6_busy_async", {31'h0, busy0}, 32'h0);
        waitCycles(2);
        rst_ni = 1'b1;
        waitCycles(5);
        checkOutput("t6_no_req", {28'h0, req0}, 32'h0);
        ackMode = 1;
        T = cyc;
        expQ.push_back('{4'b0001, T + 2});
        applyStimulus(1'b1, 4'b0000, 1'b0);
        checkOutput("t6_not_early", {28'h0, req0}, 32'h0);
        waitCycles(4);

        checkOutput("final_queue", expQ.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
